// File: rtl/sorted_serializer.sv
// Purpose: captures a packed, nominally sorted frame of 2*n elements and emits it one element per handshake, ascending or descending.
// Latency: first element is valid one cycle after capture; a frame presented during the last handshake continues with no bubble.
// Backpressure: out_ready low freezes the element, index and held frame; in_ready is high only in IDLE or on the final handshake.
module sorted_serializer #(
  parameter int WIDTH = 3,
  parameter int n     = 4   // elements per half-list; must be a power of two >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*n*WIDTH-1:0]     inc,
  input  logic                     dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(2*n)-1:0]   out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     sort_err
);

  localparam int NE   = 2 * n;
  localparam int IDXW = $clog2(NE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, state_nxt;

  // held frame and per-frame attributes
  logic [NE*WIDTH-1:0] frame_q;
  logic                dir_q;
  logic                sort_err_q;

  // emission position and registered output element
  logic [IDXW-1:0]     idx_q;
  logic [WIDTH-1:0]    data_q;

  // control strobes from the FSM
  logic                capture;
  logic                advance;
  logic                at_last;

  // element views of the incoming and held frames
  logic [WIDTH-1:0]    in_elem   [NE];
  logic [WIDTH-1:0]    held_elem [NE];
  logic                in_unsorted;
  logic [WIDTH-1:0]    first_elem;
  logic [IDXW-1:0]     nxt_idx;
  logic [IDXW-1:0]     nxt_sel;
  logic [WIDTH-1:0]    nxt_elem;

  assign at_last = (idx_q == LAST_IDX);

  // split the packed buses into element arrays; element k+1 of the spec is index k here
  always_comb begin
    for (int k = 0; k < NE; k++) begin
      in_elem[k]   = inc[k*WIDTH +: WIDTH];
      held_elem[k] = frame_q[k*WIDTH +: WIDTH];
    end
  end

  // order check on the incoming frame: any adjacent descent marks it unsorted
  always_comb begin
    in_unsorted = 1'b0;
    for (int k = 0; k < NE - 1; k++) begin
      if (in_elem[k+1] < in_elem[k]) begin
        in_unsorted = 1'b1;
      end
    end
  end

  // element shown right after capture and the element shown after each advance;
  // descending order reads the held frame from the top down
  always_comb begin
    first_elem = dir ? in_elem[NE-1] : in_elem[0];
    nxt_idx    = idx_q + IDXW'(1);
    nxt_sel    = dir_q ? (LAST_IDX - nxt_idx) : nxt_idx;
    nxt_elem   = held_elem[nxt_sel];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake decode; the final handshake doubles as an input slot
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (at_last) begin
            in_ready = 1'b1;
            if (in_valid) begin
              capture = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // frame, direction and order flag are loaded only on capture and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q    <= '0;
      dir_q      <= 1'b0;
      sort_err_q <= 1'b0;
    end else if (capture) begin
      frame_q    <= inc;
      dir_q      <= dir;
      sort_err_q <= in_unsorted;
    end
  end

  // position counter and output element register; nothing moves during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (capture) begin
      idx_q  <= '0;
      data_q <= first_elem;
    end else if (advance) begin
      idx_q  <= nxt_idx;
      data_q <= nxt_elem;
    end else if (state == STREAM && out_ready && at_last) begin
      idx_q  <= '0;
    end
  end

  assign out_data = data_q;
  assign out_idx  = idx_q;
  assign out_last = (state == STREAM) && at_last;
  assign busy     = (state == STREAM);
  assign sort_err = sort_err_q;

endmodule

// File: tb/tb_sorted_serializer.sv
// Bench for sorted_serializer with WIDTH=3, n=4.
// Expected elements are queued when a frame is driven and compared on each output handshake.
// Stall stability, latency, back-to-back, order flag and async reset are checked directly.
module tb_sorted_serializer;

  localparam int WIDTH = 3;
  localparam int N     = 4;
  localparam int NE    = 2 * N;

  typedef struct packed {
    logic [2:0] data;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NE*WIDTH-1:0] inc;
  logic            dir;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_data;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            sort_err;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  logic       stall_prev = 1'b0;
  logic [2:0] prev_data;
  logic [2:0] prev_idx;
  logic       prev_last;

  sorted_serializer #(.WIDTH(WIDTH), .n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inc       (inc),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .sort_err  (sort_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard and stall-stability monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (stall_prev) begin
        chk("stall_data", {29'd0, out_data}, {29'd0, prev_data});
        chk("stall_idx",  {29'd0, out_idx},  {29'd0, prev_idx});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {29'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {29'd0, out_data}, {29'd0, e.data});
          chk("sb_idx",  {29'd0, out_idx},  {29'd0, e.idx});
          chk("sb_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      stall_prev = !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // queue the eight elements of a frame in emission order
  task automatic push_frame(input logic [NE*WIDTH-1:0] f, input logic d);
    exp_t e;
    logic [NE*WIDTH-1:0] v;
    v = f;
    for (int i = 0; i < NE; i++) begin
      e.data = d ? v[(NE-1-i)*WIDTH +: WIDTH] : v[i*WIDTH +: WIDTH];
      e.idx  = 3'(i);
      e.last = (i == NE - 1);
      exp_q.push_back(e);
    end
  endtask

  // present a frame from IDLE; returns at the falling edge where the first element should show
  task automatic send(input logic [NE*WIDTH-1:0] f, input logic d);
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    inc      = f;
    dir      = d;
    push_frame(f, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_idx",   {29'd0, out_idx},   32'd0);
  endtask

  // run until the scoreboard empties; optionally drive out_ready with 1,0,0 repeating
  task automatic drain(input bit toggle, output int cycles);
    int k;
    k      = 1;
    cycles = 1;
    while (exp_q.size() != 0 && cycles < 200) begin
      @(posedge clk); #1;
      if (toggle) begin
        out_ready = (k % 3 == 0);
        k++;
      end
      @(negedge clk); #1;
      cycles++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    int waited;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inc       = '0;
    dir       = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {29'd0, out_data},  32'd0);
    chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_sort_err",  {31'd0, sort_err},  32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // ascending, always ready: eight consecutive cycles then IDLE
    send(24'o76543210, 1'b0);
    drain(1'b0, cyc);
    chk("asc_cycles", cyc, 32'd8);
    @(negedge clk); #1;
    chk("asc_idle_busy",  {31'd0, busy},      32'd0);
    chk("asc_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("asc_sort_err",   {31'd0, sort_err},  32'd0);

    // descending
    send(24'o76543210, 1'b1);
    drain(1'b0, cyc);
    chk("desc_cycles", cyc, 32'd8);

    // stalls with out_ready 1,0,0; inc changes mid-stream must not matter
    @(negedge clk); #1;
    send(24'o76533211, 1'b0);
    inc = 24'o01234567;
    drain(1'b1, cyc);

    // back-to-back: all 5s offered on the last handshake of a frame
    @(negedge clk); #1;
    send(24'o76543210, 1'b0);
    waited = 0;
    while (out_last !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("b2b_last_seen", {31'd0, out_last}, 32'd1);
    in_valid = 1'b1;
    inc      = 24'o55555555;
    dir      = 1'b0;
    push_frame(24'o55555555, 1'b0);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_idx",   {29'd0, out_idx},   32'd0);
    chk("b2b_data",  {29'd0, out_data},  32'd5);
    drain(1'b0, cyc);
    chk("b2b_cycles", cyc, 32'd8);

    // unsorted frame: flagged, still emitted as stored, cleared by next sorted frame
    @(negedge clk); #1;
    @(negedge clk); #1;
    send(24'o76543120, 1'b0);
    chk("sort_err_set", {31'd0, sort_err}, 32'd1);
    drain(1'b0, cyc);
    chk("sort_err_hold", {31'd0, sort_err}, 32'd1);
    @(negedge clk); #1;
    send(24'o76543210, 1'b1);
    chk("sort_err_clear", {31'd0, sort_err}, 32'd0);
    drain(1'b0, cyc);

    // asynchronous reset in mid-frame
    @(negedge clk); #1;
    send(24'o76543210, 1'b0);
    waited = 0;
    while (out_idx !== 3'd3 && waited < 50) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      waited++;
    end
    chk("mid_idx_seen", {29'd0, out_idx}, 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy",  {31'd0, busy},      32'd0);
    chk("arst_idx",   {29'd0, out_idx},   32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
    send(24'o76543210, 1'b1);
    drain(1'b0, cyc);
    chk("post_rst_cycles", cyc, 32'd8);
    @(negedge clk); #1;
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sorted_serializer.md
SORTED_SERIALIZER -- requirements
Module: sorted_serializer

Interface
REQ-001 Parameter WIDTH, default 3, bit width of one element.
REQ-002 Parameter n, default 4, elements per half-list; frame = 2*n elements; n SHALL be a power of two >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  packed sorted frame present on inc.
REQ-006 in_ready  output  1  block can accept a frame this cycle.
REQ-007 inc  input  2*n*WIDTH  packed frame; element k (k=1..2n) at bits [k*WIDTH-1:(k-1)*WIDTH]; element 1 is the smallest when sorted.
REQ-008 dir  input  1  sampled at frame capture; 0 = emit element 1 first (ascending), 1 = emit element 2n first (descending).
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element this cycle.
REQ-011 out_data  output  WIDTH  current element.
REQ-012 out_idx  output  log2(2n)  zero-based emission position within the frame (0..2n-1).
REQ-013 out_last  output  1  high with out_valid on position 2n-1 only.
REQ-014 busy  output  1  a frame is held or being emitted.
REQ-015 sort_err  output  1  the captured frame violates non-decreasing order of elements 1..2n.

Function
REQ-016 The FSM SHALL have two states, IDLE and STREAM.
REQ-017 in_ready SHALL be 1 in IDLE, and in STREAM only during the cycle in which out_valid, out_ready and out_last are all 1; otherwise 0.
REQ-018 A capture SHALL occur on a rising edge with in_valid=1 and in_ready=1; it registers inc and dir, clears the position counter to 0, and moves the FSM to STREAM.
REQ-019 In IDLE with in_valid=0, the FSM SHALL stay in IDLE.
REQ-020 In STREAM, out_valid SHALL be 1; out_valid SHALL be 0 in IDLE.
REQ-021 out_data SHALL be element (idx+1) of the held frame when dir=0, or element (2n-idx) when dir=1; it SHALL be registered, with no combinational path from inc.
REQ-022 The first element SHALL appear on out_data with out_valid=1 in the cycle after capture; latency is 1 cycle.
REQ-023 On a handshake (out_valid and out_ready both 1) with out_last=0, the position counter SHALL increment by 1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_idx, out_last and the held frame SHALL remain unchanged.
REQ-025 On a handshake with out_last=1 and in_valid=0, the FSM SHALL return to IDLE and the counter SHALL wrap to 0.
REQ-026 On a handshake with out_last=1 and in_valid=1, the new frame SHALL be captured in the same edge and the FSM SHALL stay in STREAM; this gives back-to-back frames with no bubble.
REQ-027 A change in inc or in_valid while in STREAM, outside the cycle of REQ-026, SHALL have no effect.
REQ-028 sort_err SHALL be registered at each capture as the OR over k=1..2n-1 of (element k+1 < element k), unsigned; it SHALL hold until the next capture.
REQ-029 sort_err SHALL NOT block emission; the frame is emitted in stored order regardless.
REQ-030 busy SHALL equal (state == STREAM).

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, sort_err=0, held frame=0, and held dir=0; in_ready=1 follows from IDLE.
REQ-032 Assertion of rst in mid-frame SHALL discard the frame immediately, without waiting for a clock edge; after rst deasserts, the next element output SHALL come only from a new capture.

Verification
REQ-033 Scenario: WIDTH=3, n=4, inc elements 1..8 = 0,1,2,3,4,5,6,7, dir=0, out_ready held 1 -> out_data 0..7 on 8 consecutive cycles starting one cycle after capture; out_last=1 only with 7; then IDLE.
REQ-034 Scenario: same frame, dir=1 -> out_data 7,6,...,0 with out_idx 0..7.
REQ-035 Scenario: out_ready toggles 1,0,0,1,... -> no element is lost or repeated, and outputs are stable during stalls.
REQ-036 Scenario: second frame of all 5s presented with in_valid=1 during the last handshake of the first frame -> in_ready=1 in that cycle, and the next cycle emits 5 at out_idx=0 with no gap.
REQ-037 Scenario: frame elements 1..8 = 0,2,1,3,4,5,6,7 -> sort_err=1 from the cycle after capture, and all 8 elements are still emitted in stored order; the next sorted frame clears sort_err.
REQ-038 Scenario: rst pulsed while out_idx=3 -> out_valid=0 and busy=0 immediately; a capture after reset starts again at out_idx=0.
